load_store_unit: RTL and testbench

//  Memory stage directly downstream of the ALU. Takes the ALU result as the effective address.

---
 rtl/riscv_pkg.sv | 47 ++++
 rtl/lsu_align.sv | 59 +++++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared load/store definitions: FSM states, funct3 encodings, latched request payload.
package riscv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned BE_W    = XLEN / 8;
    localparam int unsigned RD_W    = 5;
    localparam int unsigned FUNCT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        ERR
    } lsu_state_t;

    localparam logic [FUNCT_W-1:0] LS_B  = 3'b000;
    localparam logic [FUNCT_W-1:0] LS_H  = 3'b001;
    localparam logic [FUNCT_W-1:0] LS_W  = 3'b010;
    localparam logic [FUNCT_W-1:0] LS_BU = 3'b100;
    localparam logic [FUNCT_W-1:0] LS_HU = 3'b101;

    // Request fields kept after accept for the FSM and load extraction.
    typedef struct packed {
        logic               store;
        logic [FUNCT_W-1:0] funct3;
        logic [1:0]         offset;
        logic [RD_W-1:0]    rd;
    } lsu_op_t;

    // A request is rejected for an encoding that is not a legal access or a misaligned address.
    function automatic logic ls_bad(input logic store, input logic [FUNCT_W-1:0] funct3,
                                    input logic [1:0] offset);
        logic illegal;
        logic misaligned;
        if (store) begin
            illegal = !(funct3 == LS_B || funct3 == LS_H || funct3 == LS_W);
        end else begin
            illegal = !(funct3 == LS_B || funct3 == LS_H || funct3 == LS_W ||
                        funct3 == LS_BU || funct3 == LS_HU);
        end
        misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                     ((funct3[1:0] == 2'b10) && (offset != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / replication and load extract / extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]         st_offset,
    input  logic [1:0]         st_size,
    input  logic [XLEN-1:0]    st_wdata,
    input  logic [1:0]         ld_offset,
    input  logic [FUNCT_W-1:0] ld_funct3,
    input  logic [XLEN-1:0]    ld_rdata,
    output logic [BE_W-1:0]    be_c,
    output logic [XLEN-1:0]    wdata_c,
    output logic [XLEN-1:0]    rdata_c
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_signed;

    // Byte enables and lane-replicated write data from access size and address offset.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = st_wdata;
        case (st_size)
            2'b00: begin
                be_c    = 4'b0001 << st_offset;
                wdata_c = {4{st_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << {st_offset[1], 1'b0};
                wdata_c = {2{st_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = st_wdata;
            end
        endcase
    end

    // Pick the addressed lane of the read word, then sign- or zero-extend it.
    always_comb begin
        ld_byte   = ld_rdata[7:0];
        ld_half   = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_signed = !ld_funct3[2];
        rdata_c   = ld_rdata;
        case (ld_offset)
            2'b00:   ld_byte = ld_rdata[7:0];
            2'b01:   ld_byte = ld_rdata[15:8];
            2'b10:   ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        case (ld_funct3[1:0])
            2'b00:   rdata_c = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            2'b01:   rdata_c = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: rdata_c = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one outstanding access on a req/gnt/rvalid port, completion back to writeback.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_store,
    input  logic [FUNCT_W-1:0] in_funct3,
    input  logic [XLEN-1:0]    in_addr,
    input  logic [XLEN-1:0]    in_wdata,
    input  logic [RD_W-1:0]    in_rd,
    output logic               mem_req,
    output logic               mem_we,
    output logic [XLEN-1:0]    mem_addr,
    output logic [BE_W-1:0]    mem_be,
    output logic [XLEN-1:0]    mem_wdata,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [XLEN-1:0]    mem_rdata,
    output logic               done,
    output logic [RD_W-1:0]    done_rd,
    output logic [XLEN-1:0]    done_data,
    output logic               done_err
);

    localparam int unsigned CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    lsu_state_t       state;
    lsu_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    lsu_op_t          op;

    logic             accept_c;
    logic             in_bad_c;
    logic             timeout_hit_c;
    logic             finish_c;
    logic             cur_store_c;
    logic [RD_W-1:0]  cur_rd_c;
    logic [BE_W-1:0]  be_c;
    logic [XLEN-1:0]  wdata_c;
    logic [XLEN-1:0]  rdata_c;

    assign accept_c      = in_valid && (state == IDLE);
    assign in_bad_c      = ls_bad(in_store, in_funct3, in_addr[1:0]);
    assign timeout_hit_c = (TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST));
    assign finish_c      = (state_next == DONE) || (state_next == ERR);
    // A request rejected at accept has not been latched yet, so report from the inputs.
    assign cur_store_c   = (state == IDLE) ? in_store : op.store;
    assign cur_rd_c      = (state == IDLE) ? in_rd : op.rd;

    lsu_align u_align (
        .st_offset (in_addr[1:0]),
        .st_size   (in_funct3[1:0]),
        .st_wdata  (in_wdata),
        .ld_offset (op.offset),
        .ld_funct3 (op.funct3),
        .ld_rdata  (mem_rdata),
        .be_c      (be_c),
        .wdata_c   (wdata_c),
        .rdata_c   (rdata_c)
    );

    // State and timeout counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state; gnt/rvalid win over a timeout expiring in the same cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (accept_c) begin
                    state_next = in_bad_c ? ERR : REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_next = op.store ? DONE : WAIT;
                    cnt_next   = '0;
                end else if (timeout_hit_c) begin
                    state_next = ERR;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_next = DONE;
                end else if (timeout_hit_c) begin
                    state_next = ERR;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latched request, memory port and completion outputs, all registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op        <= '0;
            in_ready  <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            done_err  <= 1'b0;
            done_rd   <= '0;
            done_data <= '0;
        end else begin
            in_ready <= (state_next == IDLE);
            mem_req  <= (state_next == REQ);
            if (accept_c) begin
                op <= '{store: in_store, funct3: in_funct3, offset: in_addr[1:0], rd: in_rd};
            end
            if (accept_c && !in_bad_c) begin
                mem_we    <= in_store;
                mem_addr  <= {in_addr[XLEN-1:2], 2'b00};
                mem_be    <= be_c;
                mem_wdata <= wdata_c;
            end else if (state_next != REQ) begin
                mem_we <= 1'b0;
                mem_be <= '0;
            end
            done      <= finish_c;
            done_err  <= (state_next == ERR);
            done_rd   <= (finish_c && !cur_store_c) ? cur_rd_c : '0;
            done_data <= (state == WAIT && state_next == DONE) ? rdata_c : '0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized load/store sequences checked against an arithmetic reference model.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        done;
    logic [4:0]  done_rd;
    logic [31:0] done_data;
    logic        done_err;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_store   (in_store),
        .in_funct3  (in_funct3),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .in_rd      (in_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .done       (done),
        .done_rd    (done_rd),
        .done_data  (done_data),
        .done_err   (done_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Access size in bytes implied by funct3.
    function automatic int size_of(input logic [2:0] f3);
        int s;
        s = 1 << f3[1:0];
        return s;
    endfunction

    function automatic logic model_bad(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        int f;
        logic legal;
        f = int'(f3);
        if (st) legal = (f <= 2);
        else    legal = (f <= 2) || (f == 4) || (f == 5);
        if (!legal) return 1'b1;
        return (addr % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int m;
        m = ((1 << size_of(f3)) - 1) << (addr % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (size_of(f3))
            1:       return {24'h0, wd[7:0]} * 32'h0101_0101;
            2:       return {16'h0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int          sz;
        logic [31:0] v;
        logic [31:0] mask;
        sz = size_of(f3);
        v  = rdata >> (8 * (addr % 4));
        if (sz == 4) return v;
        mask = (32'h1 << (8 * sz)) - 32'h1;
        v    = v & mask;
        if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    // One request with gd cycles before gnt and rvd extra cycles before rvalid.
    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                         input int gd, input int rvd);
        logic b;
        int   n;
        b = model_bad(st, f3, addr);
        n = 0;
        while (!in_ready && n < 20) begin
            tick;
            n++;
        end
        chk("ready_before", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_store  = st;
        in_funct3 = f3;
        in_addr   = addr;
        in_wdata  = wd;
        in_rd     = rd;
        tick;
        in_valid  = 1'b0;
        in_addr   = $urandom;
        in_wdata  = $urandom;
        in_funct3 = 3'($urandom_range(0, 7));
        in_store  = 1'($urandom_range(0, 1));
        in_rd     = 5'($urandom_range(0, 31));
        if (b) begin
            chk("err_req", 32'(mem_req), 32'd0);
            chk("err_done", 32'(done), 32'd1);
            chk("err_flag", 32'(done_err), 32'd1);
            chk("err_rd", 32'(done_rd), st ? 32'd0 : 32'(rd));
            chk("err_data", done_data, 32'd0);
        end else begin
            for (int i = 0; i < gd; i++) begin
                chk("req_held", 32'(mem_req), 32'd1);
                chk("no_done_req", 32'(done), 32'd0);
                tick;
            end
            chk("req", 32'(mem_req), 32'd1);
            chk("we", 32'(mem_we), 32'(st));
            chk("addr", mem_addr, addr & 32'hFFFF_FFFC);
            chk("be", 32'(mem_be), 32'(model_be(f3, addr)));
            if (st) chk("wdata", mem_wdata, model_wdata(f3, wd));
            mem_gnt = 1'b1;
            tick;
            mem_gnt = 1'b0;
            if (!st) begin
                for (int i = 0; i < rvd; i++) begin
                    chk("req_dropped", 32'(mem_req), 32'd0);
                    chk("no_done_wait", 32'(done), 32'd0);
                    tick;
                end
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
                tick;
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
            chk("done", 32'(done), 32'd1);
            chk("done_err", 32'(done_err), 32'd0);
            chk("done_rd", 32'(done_rd), st ? 32'd0 : 32'(rd));
            chk("done_data", done_data, st ? 32'd0 : model_load(f3, addr, rdata));
        end
        tick;
        chk("done_pulse", 32'(done), 32'd0);
        chk("ready_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [2:0]  legal_f3 [5];
        legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
        legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_store   = 1'b0;
        in_funct3  = 3'b000;
        in_addr    = 32'h0;
        in_wdata   = 32'h0;
        in_rd      = 5'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        tick;
        tick;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(done_err), 32'd0);
        chk("rst_data", done_data, 32'd0);
        rst = 1'b0;
        tick;
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Zero-wait word load, byte loads signed/unsigned, halfword store.
        do_op(1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd5, 32'h8000_00FF, 0, 0);
        do_op(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd6, 32'h8012_3456, 0, 0);
        do_op(1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 32'h8012_3456, 0, 0);
        do_op(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd9, 32'h0, 0, 0);

        // Rejected requests: misaligned word and illegal load encoding.
        do_op(1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd3, 32'h0, 0, 0);
        do_op(1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd4, 32'h0, 0, 0);

        // Grant never arrives: request held exactly TO cycles, then error.
        in_valid  = 1'b1;
        in_store  = 1'b0;
        in_funct3 = 3'b010;
        in_addr   = 32'h0000_0400;
        in_rd     = 5'd12;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            chk("to_req_held", 32'(mem_req), 32'd1);
            tick;
        end
        chk("to_req_drop", 32'(mem_req), 32'd0);
        chk("to_done", 32'(done), 32'd1);
        chk("to_err", 32'(done_err), 32'd1);
        tick;
        chk("to_ready", 32'(in_ready), 32'd1);
        chk("to_pulse", 32'(done), 32'd0);

        // Reset while waiting for read data, followed by a stray rvalid.
        in_valid  = 1'b1;
        in_store  = 1'b0;
        in_funct3 = 3'b010;
        in_addr   = 32'h0000_0300;
        in_rd     = 5'd7;
        tick;
        in_valid = 1'b0;
        chk("rw_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        tick;
        mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        chk("rw_req_async", 32'(mem_req), 32'd0);
        chk("rw_done_async", 32'(done), 32'd0);
        tick;
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        tick;
        mem_rvalid = 1'b0;
        chk("rw_stray", 32'(done), 32'd0);
        tick;
        chk("rw_stray2", 32'(done), 32'd0);
        do_op(1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd8, 32'h1357_9BDF, 0, 1);

        // Randomized mix, mostly legal and aligned.
        for (int k = 0; k < 60; k++) begin
            st   = 1'($urandom_range(0, 1));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                f3 = st ? legal_f3[$urandom_range(0, 2)] : legal_f3[$urandom_range(0, 4)];
                addr = addr & ~(32'(size_of(f3)) - 32'd1);
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            do_op(st, f3, addr, $urandom, 5'($urandom_range(0, 31)), $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
